// File: rtl/shadow_capture_v2.sv
// Snapshot buffer with serial dump over NUM_CHAINS chains. A dump shifts out the
// local bits, then optionally forwards the upstream chains, then pulses done.
module shadow_capture_v2 #(
  parameter int DATA_W      = 16,
  parameter int NUM_CHAINS  = 2,
  parameter int DEPTH       = 4,
  parameter int OVERWRITE   = 0,
  parameter int UPSTREAM_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_en,
  input  logic [DATA_W-1:0]       din,
  input  logic                    dump_en,
  input  logic [NUM_CHAINS-1:0]   chains_in,
  input  logic [NUM_CHAINS-1:0]   chains_in_vld,
  input  logic [NUM_CHAINS-1:0]   chains_in_done,
  output logic [NUM_CHAINS-1:0]   chain_dump_en,
  output logic [NUM_CHAINS-1:0]   chains_out,
  output logic [NUM_CHAINS-1:0]   chains_out_vld,
  output logic [NUM_CHAINS-1:0]   chains_out_done,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    busy,
  output logic [1:0]              dbg_state_o
);
  localparam int CHAIN_W = DATA_W / NUM_CHAINS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BIT_W   = (CHAIN_W > 1) ? $clog2(CHAIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, UPSTREAM, FINISH} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [NUM_CHAINS-1:0]   pend_q, pend_d;
  logic [NUM_CHAINS-1:0]   fwd_bit_q, fwd_bit_d, fwd_vld_q, fwd_vld_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_W-1:0]       sh_q, sh_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    mem_we, full, pop;

  // Buffer bookkeeping; a pop in the same cycle frees the slot a full-buffer capture needs.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = (state_q == IDLE) && dump_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (capture_en) begin
      if (!full || pop) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!pop) count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (OVERWRITE != 0) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
    end else if (pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // chains_out_vld qualifies chains_out each cycle; there is no backpressure on either side.
  always_comb begin
    state_d         = state_q;
    bit_d           = bit_q;
    sh_d            = sh_q;
    pend_d          = pend_q;
    fwd_bit_d       = '0;
    fwd_vld_d       = '0;
    chain_dump_en   = '0;
    chains_out      = '0;
    chains_out_vld  = '0;
    chains_out_done = '0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        chains_out_vld = '1;
        for (int k = 0; k < NUM_CHAINS; k++) begin
          chains_out[k]                  = sh_q[k*CHAIN_W];
          sh_d[k*CHAIN_W +: CHAIN_W]     = sh_q[k*CHAIN_W +: CHAIN_W] >> 1;
        end
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_W'(CHAIN_W - 1)) begin
          if (UPSTREAM_EN != 0) begin
            state_d = UPSTREAM;
            pend_d  = '1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      UPSTREAM: begin
        chain_dump_en  = pend_q;
        chains_out     = fwd_bit_q;
        chains_out_vld = fwd_vld_q;
        fwd_bit_d      = chains_in & pend_q;
        fwd_vld_d      = chains_in_vld & pend_q;
        pend_d         = pend_q & ~chains_in_done;
        // The bit registered on the final done cycle is shown here before leaving.
        if (pend_q == '0) state_d = FINISH;
      end
      FINISH: begin
        chains_out_done = '1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      pend_q    <= '0;
      fwd_bit_q <= '0;
      fwd_vld_q <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      fwd_bit_q <= fwd_bit_d;
      fwd_vld_q <= fwd_vld_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

  assign count       = count_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
endmodule
